// File: rtl/alu_issue_decode.sv
// Decode/issue pipeline register for RV32I OP, OP-IMM, LUI and AUIPC.
// Produces ALU operands, a 4-bit select and writeback control behind a valid/ready handshake.
module alu_issue_decode #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] in_a,
  output logic [XLEN-1:0] in_b,
  output logic [3:0]      alu_select,
  output logic [4:0]      rd,
  output logic            wb_en,
  output logic            illegal
);

  localparam logic [3:0] SelAdd  = 4'b0000;
  localparam logic [3:0] SelSub  = 4'b0001;
  localparam logic [3:0] SelSll  = 4'b0010;
  localparam logic [3:0] SelSlt  = 4'b0011;
  localparam logic [3:0] SelSltu = 4'b0100;
  localparam logic [3:0] SelXor  = 4'b0101;
  localparam logic [3:0] SelSrl  = 4'b0110;
  localparam logic [3:0] SelSra  = 4'b0111;
  localparam logic [3:0] SelOr   = 4'b1000;
  localparam logic [3:0] SelAnd  = 4'b1001;

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt_r;
  logic [XLEN-1:0] shamt_i;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign imm_i   = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_u   = {instr[31:12], 12'b0};
  assign shamt_r = {{(XLEN-5){1'b0}}, rs2_data[4:0]};
  assign shamt_i = {{(XLEN-5){1'b0}}, instr[24:20]};

  logic            dec_legal;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic [3:0]      dec_sel;

  always_comb begin
    dec_legal = 1'b1;
    dec_a     = rs1_data;
    dec_b     = rs2_data;
    dec_sel   = SelAdd;
    case (opcode)
      OpcOp: begin
        if (funct7 == F7Base) begin
          case (funct3)
            3'b000: dec_sel = SelAdd;
            3'b001: begin
              dec_sel = SelSll;
              dec_b   = shamt_r;
            end
            3'b010: dec_sel = SelSlt;
            3'b011: dec_sel = SelSltu;
            3'b100: dec_sel = SelXor;
            3'b101: begin
              dec_sel = SelSrl;
              dec_b   = shamt_r;
            end
            3'b110: dec_sel = SelOr;
            3'b111: dec_sel = SelAnd;
            default: dec_legal = 1'b0;
          endcase
        end else if (funct7 == F7Alt && funct3 == 3'b000) begin
          dec_sel = SelSub;
        end else if (funct7 == F7Alt && funct3 == 3'b101) begin
          dec_sel = SelSra;
          dec_b   = shamt_r;
        end else begin
          dec_legal = 1'b0;
        end
      end
      OpcOpImm: begin
        dec_b = imm_i;
        case (funct3)
          3'b000: dec_sel = SelAdd;
          3'b001: begin
            dec_sel   = SelSll;
            dec_b     = shamt_i;
            dec_legal = (funct7 == F7Base);
          end
          3'b010: dec_sel = SelSlt;
          3'b011: dec_sel = SelSltu;
          3'b100: dec_sel = SelXor;
          3'b101: begin
            dec_b = shamt_i;
            if (funct7 == F7Base) begin
              dec_sel = SelSrl;
            end else if (funct7 == F7Alt) begin
              dec_sel = SelSra;
            end else begin
              dec_legal = 1'b0;
            end
          end
          3'b110: dec_sel = SelOr;
          3'b111: dec_sel = SelAnd;
          default: dec_legal = 1'b0;
        endcase
      end
      OpcLui: begin
        dec_a = '0;
        dec_b = imm_u;
      end
      OpcAuipc: begin
        dec_a = pc;
        dec_b = imm_u;
      end
      default: dec_legal = 1'b0;
    endcase
    // Illegal entries still flow, but carry neutral operands and no writeback.
    if (!dec_legal) begin
      dec_a   = '0;
      dec_b   = '0;
      dec_sel = SelAdd;
    end
  end

  logic            valid_q, valid_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [3:0]      sel_q, sel_d;
  logic [4:0]      rd_q, rd_d;
  logic            wb_q, wb_d;
  logic            ill_q, ill_d;
  logic            load;

  // flush is included so a flushed slot is visibly free to upstream.
  assign in_ready = flush || !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    rd_d    = rd_q;
    wb_d    = wb_q;
    ill_d   = ill_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      a_d     = dec_a;
      b_d     = dec_b;
      sel_d   = dec_sel;
      rd_d    = instr[11:7];
      wb_d    = dec_legal && (instr[11:7] != 5'd0);
      ill_d   = !dec_legal;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= 4'b0000;
      rd_q    <= 5'd0;
      wb_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
      wb_q    <= wb_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid  = valid_q;
  assign in_a       = a_q;
  assign in_b       = b_q;
  assign alu_select = sel_q;
  assign rd         = rd_q;
  assign wb_en      = wb_q;
  assign illegal    = ill_q;

endmodule

// File: tb/tb_alu_issue_decode.sv
// Directed bench for alu_issue_decode: decode vectors, handshake, backpressure, flush and reset.
module tb_alu_issue_decode;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  alu_select;
  logic [4:0]  rd;
  logic        wb_en;
  logic        illegal;

  int checks;
  int failures;
  logic [31:0] xfer_log[$];

  alu_issue_decode #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .alu_select(alu_select),
    .rd        (rd),
    .wb_en     (wb_en),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change only at posedge+1, so a handshake seen at negedge completes at the next posedge.
  always @(negedge clk) begin
    if (out_valid && out_ready) xfer_log.push_back(in_b);
  end

  task automatic issue(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2);
    instr    = i;
    pc       = p;
    rs1_data = r1;
    rs2_data = r2;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_a !== 32'h0 || in_b !== 32'h0 || alu_select !== 4'h0 ||
        rd !== 5'd0 || wb_en !== 1'b0 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got v=%b a=%h b=%h sel=%h rd=%0d wb=%b ill=%b, want all zero",
               out_valid, in_a, in_b, alu_select, rd, wb_en, illegal);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_op_imm;
    issue(32'h00500093, 32'h0, 32'h0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || in_a !== 32'h0 || in_b !== 32'h5 || alu_select !== 4'b0000 ||
        rd !== 5'd1 || wb_en !== 1'b1 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL addi_pos: got v=%b a=%h b=%h sel=%b rd=%0d wb=%b ill=%b, want 1 0 5 0000 1 1 0",
               out_valid, in_a, in_b, alu_select, rd, wb_en, illegal);
    end
    issue(32'hFFF00093, 32'h0, 32'h0, 32'h0);
    checks++;
    if (in_b !== 32'hFFFFFFFF || alu_select !== 4'b0000) begin
      failures++;
      $display("FAIL addi_neg: got b=%h sel=%b want ffffffff 0000", in_b, alu_select);
    end
    issue(32'h40335293, 32'h0, 32'h80000000, 32'h0);
    checks++;
    if (in_a !== 32'h80000000 || in_b !== 32'h3 || alu_select !== 4'b0111 || rd !== 5'd5) begin
      failures++;
      $display("FAIL srai: got a=%h b=%h sel=%b rd=%0d want 80000000 3 0111 5",
               in_a, in_b, alu_select, rd);
    end
  endtask

  task automatic test_op;
    issue(32'h402081B3, 32'h0, 32'd10, 32'd3);
    checks++;
    if (in_a !== 32'd10 || in_b !== 32'd3 || alu_select !== 4'b0001 || rd !== 5'd3 ||
        wb_en !== 1'b1) begin
      failures++;
      $display("FAIL sub: got a=%h b=%h sel=%b rd=%0d wb=%b want a 3 0001 3 1",
               in_a, in_b, alu_select, rd, wb_en);
    end
    issue(32'h00209233, 32'h0, 32'h1, 32'hFFFFFF25);
    checks++;
    if (in_b !== 32'h5 || alu_select !== 4'b0010 || rd !== 5'd4) begin
      failures++;
      $display("FAIL sll: got b=%h sel=%b rd=%0d want 5 0010 4", in_b, alu_select, rd);
    end
    // ADD x0: legal but must not write back
    issue(32'h00208033, 32'h0, 32'h1, 32'h2);
    checks++;
    if (wb_en !== 1'b0 || illegal !== 1'b0 || rd !== 5'd0) begin
      failures++;
      $display("FAIL add_x0: got wb=%b ill=%b rd=%0d want 0 0 0", wb_en, illegal, rd);
    end
  endtask

  task automatic test_upper;
    issue(32'h123453B7, 32'h200, 32'hDEADBEEF, 32'h0);
    checks++;
    if (in_a !== 32'h0 || in_b !== 32'h12345000 || alu_select !== 4'b0000 || rd !== 5'd7) begin
      failures++;
      $display("FAIL lui: got a=%h b=%h sel=%b rd=%0d want 0 12345000 0000 7",
               in_a, in_b, alu_select, rd);
    end
    issue(32'h12345397, 32'h100, 32'hDEADBEEF, 32'h0);
    checks++;
    if (in_a !== 32'h100 || in_b !== 32'h12345000 || alu_select !== 4'b0000 || rd !== 5'd7) begin
      failures++;
      $display("FAIL auipc: got a=%h b=%h sel=%b rd=%0d want 100 12345000 0000 7",
               in_a, in_b, alu_select, rd);
    end
  endtask

  task automatic test_illegal;
    issue(32'h0000007F, 32'h40, 32'h11, 32'h22);
    checks++;
    if (out_valid !== 1'b1 || illegal !== 1'b1 || wb_en !== 1'b0 || alu_select !== 4'b0000 ||
        in_a !== 32'h0 || in_b !== 32'h0 || rd !== 5'd0) begin
      failures++;
      $display("FAIL ill_opcode: got v=%b ill=%b wb=%b sel=%b a=%h b=%h rd=%0d want 1 1 0 0 0 0 0",
               out_valid, illegal, wb_en, alu_select, in_a, in_b, rd);
    end
    issue(32'h02208233, 32'h0, 32'd10, 32'd3);
    checks++;
    if (illegal !== 1'b1 || wb_en !== 1'b0 || alu_select !== 4'b0000 || in_a !== 32'h0 ||
        in_b !== 32'h0 || rd !== 5'd4) begin
      failures++;
      $display("FAIL ill_funct7: got ill=%b wb=%b sel=%b a=%h b=%h rd=%0d want 1 0 0 0 0 4",
               illegal, wb_en, alu_select, in_a, in_b, rd);
    end
    // SLLI with nonzero funct7
    issue(32'h02109093, 32'h0, 32'h5, 32'h0);
    checks++;
    if (illegal !== 1'b1 || wb_en !== 1'b0) begin
      failures++;
      $display("FAIL ill_slli: got ill=%b wb=%b want 1 0", illegal, wb_en);
    end
  endtask

  task automatic test_back_to_back;
    instr    = 32'h402081B3;
    rs1_data = 32'd20;
    rs2_data = 32'd7;
    pc       = 32'h0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || alu_select !== 4'b0001 || in_a !== 32'd20 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first: got v=%b sel=%b a=%h rdy=%b want 1 0001 14 1",
               out_valid, alu_select, in_a, in_ready);
    end
    instr    = 32'h00209233;
    rs2_data = 32'h00000043;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || alu_select !== 4'b0010 || in_b !== 32'h3) begin
      failures++;
      $display("FAIL b2b_second: got v=%b sel=%b b=%h want 1 0010 3", out_valid, alu_select, in_b);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_b !== 32'h3) begin
      failures++;
      $display("FAIL b2b_drain: got v=%b b=%h want 0 3 (data holds)", out_valid, in_b);
    end
  endtask

  task automatic test_backpressure;
    xfer_log.delete();
    out_ready = 1'b0;
    issue(32'h00500093, 32'h0, 32'h0, 32'h0);
    instr    = 32'h00600113;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_b !== 32'h5 || rd !== 5'd1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_%0d: got v=%b b=%h rd=%0d rdy=%b want 1 5 1 0",
                 i, out_valid, in_b, rd, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    instr = 32'h00700193;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (xfer_log.size() != 3) begin
      failures++;
      $display("FAIL bp_count: got %0d transfers want 3", xfer_log.size());
    end else begin
      checks++;
      if (xfer_log[0] !== 32'h5 || xfer_log[1] !== 32'h6 || xfer_log[2] !== 32'h7) begin
        failures++;
        $display("FAIL bp_order: got %h %h %h want 5 6 7", xfer_log[0], xfer_log[1], xfer_log[2]);
      end
    end
  endtask

  task automatic test_flush;
    xfer_log.delete();
    out_ready = 1'b0;
    issue(32'h00800213, 32'h0, 32'h0, 32'h0);
    instr    = 32'h00900293;
    in_valid = 1'b1;
    flush    = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_ready: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_kill: got v=%b want 0", out_valid);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || xfer_log.size() != 0) begin
      failures++;
      $display("FAIL flush_drop: got v=%b transfers=%0d want 0 0", out_valid, xfer_log.size());
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    issue(32'h00500093, 32'h0, 32'h0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_b !== 32'h0 || rd !== 5'd0 || wb_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: got v=%b b=%h rd=%0d wb=%b want 0 0 0 0", out_valid, in_b, rd, wb_en);
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    instr     = 32'h0;
    pc        = 32'h0;
    rs1_data  = 32'h0;
    rs2_data  = 32'h0;
    #1;
    test_reset();
    test_op_imm();
    test_op();
    test_upper();
    test_illegal();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
